// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl: shares one expand_8bit_addr adder among NREQ requesters.
// A round-robin arbiter picks one requester at a time. The block programs the
// adder's mode register (offset-add enable) only when the requested mode differs
// from the last mode written. It then issues the operands and returns the
// registered sum and carry to the winner. Host offset loads have priority over
// new grants. A result that does not arrive in time is answered with an error.
//
// Ports
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   req/req_a/req_b       : per-requester request level and packed operands
//   req_use_off           : per-requester select, 1 = A+B+offset
//   cfg_off_valid/_value  : host offset load; cfg_off_done pulses when issued
//   rsp_valid/_sum/_carry/_err : one-hot response pulse with result
//   busy                  : high whenever the sequencer is not idle
//   add_*                 : master side of the adder's data and register ports
module adder_share_ctrl #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]   req_use_off,
  input  logic              cfg_off_valid,
  input  logic [7:0]        cfg_off_value,
  output logic              cfg_off_done,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_sum,
  output logic              rsp_carry,
  output logic              rsp_err,
  output logic              busy,
  output logic [7:0]        add_value_a,
  output logic [7:0]        add_value_b,
  output logic              add_data_val,
  output logic              add_des_reg_valid,
  output logic              add_des_wr_rd,
  output logic [2:0]        add_des_address,
  output logic [7:0]        add_des_value,
  input  logic [7:0]        add_sum_result,
  input  logic              add_sum_carry,
  input  logic              add_data_ready
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StOffwr = 3'd1;
  localparam logic [2:0] StCfg   = 3'd2;
  localparam logic [2:0] StIssue = 3'd3;
  localparam logic [2:0] StWait  = 3'd4;
  localparam logic [2:0] StResp  = 3'd5;

  localparam logic [2:0] AddrMode = 3'b000;
  localparam logic [2:0] AddrOff  = 3'b001;

  logic [2:0]      state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic            use_off_q, use_off_d;
  logic            mode_q, mode_d;
  logic            mode_vld_q, mode_vld_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

  logic            cfg_off_done_q, cfg_off_done_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_sum_q, rsp_sum_d;
  logic            rsp_carry_q, rsp_carry_d;
  logic            rsp_err_q, rsp_err_d;
  logic            busy_q, busy_d;
  logic [7:0]      add_value_a_q, add_value_a_d;
  logic [7:0]      add_value_b_q, add_value_b_d;
  logic            add_data_val_q, add_data_val_d;
  logic            add_des_reg_valid_q, add_des_reg_valid_d;
  logic            add_des_wr_rd_q, add_des_wr_rd_d;
  logic [2:0]      add_des_address_q, add_des_address_d;
  logic [7:0]      add_des_value_q, add_des_value_d;

  // Unpacked views of the packed operand buses.
  logic [7:0]      op_a_arr [NREQ];
  logic [7:0]      op_b_arr [NREQ];
  // Candidate index for each round-robin search position, starting at rr_ptr.
  logic [IdxW-1:0] cand [NREQ];
  logic            scan_found;
  logic [IdxW-1:0] scan_idx;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      op_a_arr[i] = req_a[8*i +: 8];
      op_b_arr[i] = req_b[8*i +: 8];
      cand[i]     = IdxW'((32'(rr_ptr_q) + i) % NREQ);
    end
  end

  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!scan_found && req[cand[k]]) begin
        scan_found = 1'b1;
        scan_idx   = cand[k];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    use_off_d  = use_off_q;
    mode_d     = mode_q;
    mode_vld_d = mode_vld_q;
    wait_cnt_d = wait_cnt_q;

    // Pulsed outputs default low; operands hold their last value.
    cfg_off_done_d      = 1'b0;
    rsp_valid_d         = '0;
    rsp_sum_d           = '0;
    rsp_carry_d         = 1'b0;
    rsp_err_d           = 1'b0;
    add_value_a_d       = add_value_a_q;
    add_value_b_d       = add_value_b_q;
    add_data_val_d      = 1'b0;
    add_des_reg_valid_d = 1'b0;
    add_des_wr_rd_d     = 1'b0;
    add_des_address_d   = '0;
    add_des_value_d     = '0;

    case (state_q)
      StIdle: begin
        if (cfg_off_valid) begin
          state_d             = StOffwr;
          add_des_reg_valid_d = 1'b1;
          add_des_wr_rd_d     = 1'b1;
          add_des_address_d   = AddrOff;
          add_des_value_d     = cfg_off_value;
          cfg_off_done_d      = 1'b1;
        end else if (scan_found) begin
          grant_d       = scan_idx;
          use_off_d     = req_use_off[scan_idx];
          add_value_a_d = op_a_arr[scan_idx];
          add_value_b_d = op_b_arr[scan_idx];
          if (!mode_vld_q || (mode_q != req_use_off[scan_idx])) begin
            state_d             = StCfg;
            add_des_reg_valid_d = 1'b1;
            add_des_wr_rd_d     = 1'b1;
            add_des_address_d   = AddrMode;
            add_des_value_d     = {7'b0, req_use_off[scan_idx]};
          end else begin
            state_d        = StIssue;
            add_data_val_d = 1'b1;
          end
        end
      end
      StOffwr: state_d = StIdle;
      StCfg: begin
        mode_d         = use_off_q;
        mode_vld_d     = 1'b1;
        state_d        = StIssue;
        add_data_val_d = 1'b1;
      end
      StIssue: begin
        state_d    = StWait;
        wait_cnt_d = '0;
      end
      StWait: begin
        if (add_data_ready) begin
          state_d     = StResp;
          rsp_valid_d = NREQ'(1) << grant_q;
          rsp_sum_d   = add_sum_result;
          rsp_carry_d = add_sum_carry;
        end else if (wait_cnt_q == CntW'(TIMEOUT - 1)) begin
          // Adder state is now unknown, so force a mode rewrite next time.
          state_d     = StResp;
          rsp_valid_d = NREQ'(1) << grant_q;
          rsp_err_d   = 1'b1;
          mode_vld_d  = 1'b0;
          wait_cnt_d  = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StResp: begin
        rr_ptr_d = (grant_q == IdxW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= StIdle;
      rr_ptr_q            <= '0;
      grant_q             <= '0;
      use_off_q           <= 1'b0;
      mode_q              <= 1'b0;
      mode_vld_q          <= 1'b0;
      wait_cnt_q          <= '0;
      cfg_off_done_q      <= 1'b0;
      rsp_valid_q         <= '0;
      rsp_sum_q           <= '0;
      rsp_carry_q         <= 1'b0;
      rsp_err_q           <= 1'b0;
      busy_q              <= 1'b0;
      add_value_a_q       <= '0;
      add_value_b_q       <= '0;
      add_data_val_q      <= 1'b0;
      add_des_reg_valid_q <= 1'b0;
      add_des_wr_rd_q     <= 1'b0;
      add_des_address_q   <= '0;
      add_des_value_q     <= '0;
    end else begin
      state_q             <= state_d;
      rr_ptr_q            <= rr_ptr_d;
      grant_q             <= grant_d;
      use_off_q           <= use_off_d;
      mode_q              <= mode_d;
      mode_vld_q          <= mode_vld_d;
      wait_cnt_q          <= wait_cnt_d;
      cfg_off_done_q      <= cfg_off_done_d;
      rsp_valid_q         <= rsp_valid_d;
      rsp_sum_q           <= rsp_sum_d;
      rsp_carry_q         <= rsp_carry_d;
      rsp_err_q           <= rsp_err_d;
      busy_q              <= busy_d;
      add_value_a_q       <= add_value_a_d;
      add_value_b_q       <= add_value_b_d;
      add_data_val_q      <= add_data_val_d;
      add_des_reg_valid_q <= add_des_reg_valid_d;
      add_des_wr_rd_q     <= add_des_wr_rd_d;
      add_des_address_q   <= add_des_address_d;
      add_des_value_q     <= add_des_value_d;
    end
  end

  assign cfg_off_done      = cfg_off_done_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_sum           = rsp_sum_q;
  assign rsp_carry         = rsp_carry_q;
  assign rsp_err           = rsp_err_q;
  assign busy              = busy_q;
  assign add_value_a       = add_value_a_q;
  assign add_value_b       = add_value_b_q;
  assign add_data_val      = add_data_val_q;
  assign add_des_reg_valid = add_des_reg_valid_q;
  assign add_des_wr_rd     = add_des_wr_rd_q;
  assign add_des_address   = add_des_address_q;
  assign add_des_value     = add_des_value_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Testbench for adder_share_ctrl. It contains a behavioural model of the shared
// adder with mode and offset registers and a one-cycle result. Expected results
// come from a request-level model: offset value, last programmed mode, and the
// round-robin pointer.
module tb_adder_share_ctrl;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [8*NREQ-1:0] req_a = '0;
  logic [8*NREQ-1:0] req_b = '0;
  logic [NREQ-1:0]   req_use_off = '0;
  logic              cfg_off_valid = 1'b0;
  logic [7:0]        cfg_off_value = '0;
  logic              cfg_off_done;
  logic [NREQ-1:0]   rsp_valid;
  logic [7:0]        rsp_sum;
  logic              rsp_carry, rsp_err, busy;
  logic [7:0]        add_value_a, add_value_b;
  logic              add_data_val, add_des_reg_valid, add_des_wr_rd;
  logic [2:0]        add_des_address;
  logic [7:0]        add_des_value;
  logic [7:0]        add_sum_result = '0;
  logic              add_sum_carry = 1'b0;
  logic              add_data_ready = 1'b0;

  adder_share_ctrl #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
    .req_use_off(req_use_off), .cfg_off_valid(cfg_off_valid), .cfg_off_value(cfg_off_value),
    .cfg_off_done(cfg_off_done), .rsp_valid(rsp_valid), .rsp_sum(rsp_sum),
    .rsp_carry(rsp_carry), .rsp_err(rsp_err), .busy(busy), .add_value_a(add_value_a),
    .add_value_b(add_value_b), .add_data_val(add_data_val),
    .add_des_reg_valid(add_des_reg_valid), .add_des_wr_rd(add_des_wr_rd),
    .add_des_address(add_des_address), .add_des_value(add_des_value),
    .add_sum_result(add_sum_result), .add_sum_carry(add_sum_carry),
    .add_data_ready(add_data_ready)
  );

  always #5 clk = ~clk;

  // Shared adder model; its registers are deliberately not cleared by reset.
  logic       adr_mode = 1'b0;
  logic [7:0] adr_off = '0;
  logic       ready_en = 1'b1;
  logic [9:0] adr_tot;
  assign adr_tot = {2'b0, add_value_a} + {2'b0, add_value_b} + (adr_mode ? {2'b0, adr_off} : 10'd0);

  always @(posedge clk) begin
    if (add_des_reg_valid && add_des_wr_rd && add_des_address == 3'd0) adr_mode <= add_des_value[0];
    if (add_des_reg_valid && add_des_wr_rd && add_des_address == 3'd1) adr_off <= add_des_value;
    if (add_data_val) begin
      add_sum_result <= adr_tot[7:0];
      add_sum_carry  <= (adr_tot > 10'd255);
    end
    add_data_ready <= add_data_val && ready_en && !reset;
  end

  // Bus monitors, sampled mid-cycle.
  int cfg_wr_cnt = 0;
  int overlap_cnt = 0;
  always @(negedge clk) begin
    if (add_des_reg_valid && add_des_wr_rd && add_des_address == 3'd0) cfg_wr_cnt++;
    if (add_des_reg_valid && add_data_val) overlap_cnt++;
  end

  logic [45:0] all_outs;
  assign all_outs = {cfg_off_done, rsp_valid, rsp_sum, rsp_carry, rsp_err, busy, add_value_a,
                     add_value_b, add_data_val, add_des_reg_valid, add_des_wr_rd,
                     add_des_address, add_des_value};

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] model_off = '0;
  logic       model_mode = 1'b0;
  logic       model_mode_vld = 1'b0;
  int         model_ptr = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output int lat, output logic [NREQ-1:0] v, output logic [7:0] s,
                          output logic c, output logic e);
    lat = -1; v = '0; s = '0; c = 1'b0; e = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (rsp_valid !== '0) begin
        lat = i; v = rsp_valid; s = rsp_sum; c = rsp_carry; e = rsp_err;
        break;
      end
    end
  endtask

  task automatic drive_req(int idx, logic [7:0] a, logic [7:0] b, logic u);
    req_a[8*idx +: 8] = a;
    req_b[8*idx +: 8] = b;
    req_use_off[idx]  = u;
    req[idx]          = 1'b1;
  endtask

  task automatic single_op(int idx, logic [7:0] a, logic [7:0] b, logic u, output int lat,
                           output logic [NREQ-1:0] v, output logic [7:0] s, output logic c,
                           output logic e);
    drive_req(idx, a, b, u);
    wait_rsp(lat, v, s, c, e);
    req[idx] = 1'b0;
    step();
  endtask

  // {carry, sum} of a request under the current host offset.
  function automatic logic [8:0] exp_result(logic [7:0] a, logic [7:0] b, logic u);
    int t;
    t = int'(a) + int'(b) + (u ? int'(model_off) : 0);
    return {(t > 255), t[7:0]};
  endfunction

  // Cycles from grant to response: one extra when the mode must be rewritten.
  function automatic int exp_lat(logic u);
    return (model_mode_vld && model_mode == u) ? 3 : 4;
  endfunction

  function automatic int pick(logic [NREQ-1:0] m, int ptr);
    for (int k = 0; k < NREQ; k++) if (m[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(int g);
    logic [NREQ-1:0] r;
    r = '0;
    r[g] = 1'b1;
    return r;
  endfunction

  task automatic apply_reset();
    reset = 1'b1; req = '0; cfg_off_valid = 1'b0;
    step(); step();
    reset = 1'b0;
    model_mode_vld = 1'b0; model_ptr = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_checks++; if (all_outs !== '0) begin n_fail++; $display("FAIL reset_outs: got %0h expected 0", all_outs); end
    reset = 1'b0;
    step(); step();
    n_checks++; if (all_outs !== '0) begin n_fail++; $display("FAIL idle_outs: got %0h expected 0", all_outs); end
    model_mode_vld = 1'b0; model_ptr = 0;
  endtask

  task automatic test_basic();
    int lat; logic [NREQ-1:0] v; logic [7:0] s; logic c, e; int cfg0;
    cfg0 = cfg_wr_cnt;
    drive_req(2, 8'h12, 8'h34, 1'b0);
    step();
    n_checks++;
    if ({add_des_reg_valid, add_des_wr_rd, add_des_address, add_des_value, add_data_val} !== {1'b1, 1'b1, 3'd0, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL basic_cfg: got %0h expected %0h", {add_des_reg_valid, add_des_wr_rd, add_des_address, add_des_value, add_data_val}, {1'b1, 1'b1, 3'd0, 8'h00, 1'b0});
    end
    step();
    n_checks++;
    if ({add_data_val, add_des_reg_valid, add_value_a, add_value_b} !== {1'b1, 1'b0, 8'h12, 8'h34}) begin
      n_fail++; $display("FAIL basic_issue: got %0h expected %0h", {add_data_val, add_des_reg_valid, add_value_a, add_value_b}, {1'b1, 1'b0, 8'h12, 8'h34});
    end
    wait_rsp(lat, v, s, c, e);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL basic_latency: got %0d expected 2", lat); end
    n_checks++; if (v !== 4'b0100) begin n_fail++; $display("FAIL basic_rsp_valid: got %b expected 0100", v); end
    n_checks++; if ({c, e, s} !== {1'b0, 1'b0, 8'h46}) begin n_fail++; $display("FAIL basic_result: got %0h expected 46", {c, e, s}); end
    req[2] = 1'b0;
    step();
    n_checks++; if (cfg_wr_cnt - cfg0 !== 1) begin n_fail++; $display("FAIL basic_cfg_count: got %0d expected 1", cfg_wr_cnt - cfg0); end
    model_mode_vld = 1'b1; model_mode = 1'b0; model_ptr = 3;
  endtask

  task automatic test_offset();
    int lat; logic [NREQ-1:0] v; logic [7:0] s; logic c, e;
    cfg_off_valid = 1'b1; cfg_off_value = 8'h05;
    step();
    n_checks++;
    if ({cfg_off_done, busy, add_des_reg_valid, add_des_wr_rd, add_des_address, add_des_value, add_data_val} !== {4'b1111, 3'd1, 8'h05, 1'b0}) begin
      n_fail++; $display("FAIL offwr: got %0h expected %0h", {cfg_off_done, busy, add_des_reg_valid, add_des_wr_rd, add_des_address, add_des_value, add_data_val}, {4'b1111, 3'd1, 8'h05, 1'b0});
    end
    cfg_off_valid = 1'b0; model_off = 8'h05;
    step();
    n_checks++; if ({cfg_off_done, busy, add_des_reg_valid} !== 3'b000) begin n_fail++; $display("FAIL offwr_return: got %b expected 000", {cfg_off_done, busy, add_des_reg_valid}); end
    drive_req(0, 8'hF0, 8'h0F, 1'b1);
    step();
    n_checks++;
    if ({add_des_reg_valid, add_des_wr_rd, add_des_address, add_des_value} !== {1'b1, 1'b1, 3'd0, 8'h01}) begin
      n_fail++; $display("FAIL offset_cfg: got %0h expected %0h", {add_des_reg_valid, add_des_wr_rd, add_des_address, add_des_value}, {1'b1, 1'b1, 3'd0, 8'h01});
    end
    wait_rsp(lat, v, s, c, e);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL offset_latency: got %0d expected 3", lat); end
    n_checks++; if (v !== 4'b0001) begin n_fail++; $display("FAIL offset_rsp_valid: got %b expected 0001", v); end
    n_checks++; if ({c, e, s} !== {1'b1, 1'b0, 8'h04}) begin n_fail++; $display("FAIL offset_result: got %0h expected 204", {c, e, s}); end
    req[0] = 1'b0;
    step();
    model_mode_vld = 1'b1; model_mode = 1'b1; model_ptr = 1;
  endtask

  task automatic test_simultaneous();
    int lat, idx, el; logic [NREQ-1:0] v; logic [7:0] s, a, b, off; logic c, e, u; logic [8:0] er;
    idx = $urandom_range(0, NREQ - 1); a = 8'($urandom); b = 8'($urandom);
    u = 1'($urandom); off = 8'($urandom);
    cfg_off_valid = 1'b1; cfg_off_value = off;
    drive_req(idx, a, b, u);
    step();
    n_checks++;
    if ({add_des_reg_valid, add_des_address, add_des_value, cfg_off_done, add_data_val} !== {1'b1, 3'd1, off, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL simul_offwr_first: got %0h expected %0h", {add_des_reg_valid, add_des_address, add_des_value, cfg_off_done, add_data_val}, {1'b1, 3'd1, off, 1'b1, 1'b0});
    end
    cfg_off_valid = 1'b0; model_off = off;
    er = exp_result(a, b, u); el = 1 + exp_lat(u);
    wait_rsp(lat, v, s, c, e);
    n_checks++; if (lat !== el) begin n_fail++; $display("FAIL simul_latency: got %0d expected %0d", lat, el); end
    n_checks++; if ({v, e, c, s} !== {onehot(idx), 1'b0, er}) begin n_fail++; $display("FAIL simul_rsp: got %0h expected %0h", {v, e, c, s}, {onehot(idx), 1'b0, er}); end
    req[idx] = 1'b0;
    step();
    model_mode_vld = 1'b1; model_mode = u; model_ptr = (idx + 1) % NREQ;
  endtask

  task automatic test_random_ops(int n);
    int lat, idx, el; logic [NREQ-1:0] v; logic [7:0] s, a, b; logic c, e, u; logic [8:0] er;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        cfg_off_valid = 1'b1; cfg_off_value = 8'($urandom);
        step();
        cfg_off_valid = 1'b0; model_off = cfg_off_value;
        step();
      end
      idx = $urandom_range(0, NREQ - 1); a = 8'($urandom); b = 8'($urandom); u = 1'($urandom);
      er = exp_result(a, b, u); el = exp_lat(u);
      single_op(idx, a, b, u, lat, v, s, c, e);
      n_checks++; if (lat !== el) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, el); end
      n_checks++; if (v !== onehot(idx)) begin n_fail++; $display("FAIL rand_rsp_valid[%0d]: got %b expected %b", i, v, onehot(idx)); end
      n_checks++; if ({e, c, s} !== {1'b0, er}) begin n_fail++; $display("FAIL rand_result[%0d]: got %0h expected %0h", i, {e, c, s}, {1'b0, er}); end
      model_mode_vld = 1'b1; model_mode = u; model_ptr = (idx + 1) % NREQ;
    end
  endtask

  task automatic test_alternate(int n);
    int lat, idx, cfg0; logic [NREQ-1:0] v; logic [7:0] s, a, b; logic c, e, u; logic [8:0] er;
    cfg0 = cfg_wr_cnt;
    u = model_mode_vld ? !model_mode : 1'b0;
    for (int i = 0; i < n; i++) begin
      idx = $urandom_range(0, NREQ - 1); a = 8'($urandom); b = 8'($urandom);
      er = exp_result(a, b, u);
      single_op(idx, a, b, u, lat, v, s, c, e);
      n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL alt_latency[%0d]: got %0d expected 4", i, lat); end
      n_checks++; if ({v, e, c, s} !== {onehot(idx), 1'b0, er}) begin n_fail++; $display("FAIL alt_rsp[%0d]: got %0h expected %0h", i, {v, e, c, s}, {onehot(idx), 1'b0, er}); end
      model_mode_vld = 1'b1; model_mode = u; model_ptr = (idx + 1) % NREQ;
      u = !u;
    end
    n_checks++; if (cfg_wr_cnt - cfg0 !== n) begin n_fail++; $display("FAIL alt_cfg_count: got %0d expected %0d", cfg_wr_cnt - cfg0, n); end
  endtask

  task automatic test_back_to_back();
    int lat, cfg0, g; logic [NREQ-1:0] v; logic [7:0] s; logic c, e;
    logic [7:0] av [NREQ]; logic [7:0] bv [NREQ];
    apply_reset();
    cfg0 = cfg_wr_cnt;
    for (int i = 0; i < NREQ; i++) begin
      av[i] = 8'($urandom); bv[i] = 8'($urandom);
      drive_req(i, av[i], bv[i], 1'b0);
    end
    for (int k = 0; k < 5; k++) begin
      g = k % NREQ;
      wait_rsp(lat, v, s, c, e);
      n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d expected 4", k, lat); end
      n_checks++; if ({v, e, c, s} !== {onehot(g), 1'b0, exp_result(av[g], bv[g], 1'b0)}) begin
        n_fail++; $display("FAIL b2b_rsp[%0d]: got %0h expected %0h", k, {v, e, c, s}, {onehot(g), 1'b0, exp_result(av[g], bv[g], 1'b0)});
      end
    end
    req = '0;
    step();
    n_checks++; if (cfg_wr_cnt - cfg0 !== 1) begin n_fail++; $display("FAIL b2b_cfg_count: got %0d expected 1", cfg_wr_cnt - cfg0); end
    model_mode_vld = 1'b1; model_mode = 1'b0; model_ptr = 1;
  endtask

  task automatic test_arbitration(int rounds);
    int lat, g, el; logic [NREQ-1:0] v, pending; logic [7:0] s; logic c, e, first; logic [8:0] er;
    logic [7:0] av [NREQ]; logic [7:0] bv [NREQ]; logic uv [NREQ];
    for (int r = 0; r < rounds; r++) begin
      pending = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        av[i] = 8'($urandom); bv[i] = 8'($urandom); uv[i] = 1'($urandom);
        if (pending[i]) drive_req(i, av[i], bv[i], uv[i]);
      end
      first = 1'b1;
      while (pending != '0) begin
        g = pick(pending, model_ptr);
        el = (first ? 0 : 1) + exp_lat(uv[g]);
        er = exp_result(av[g], bv[g], uv[g]);
        wait_rsp(lat, v, s, c, e);
        n_checks++; if (lat !== el) begin n_fail++; $display("FAIL arb_latency[%0d]: got %0d expected %0d", r, lat, el); end
        n_checks++; if ({v, e, c, s} !== {onehot(g), 1'b0, er}) begin n_fail++; $display("FAIL arb_grant[%0d]: got %0h expected %0h", r, {v, e, c, s}, {onehot(g), 1'b0, er}); end
        req[g] = 1'b0; pending[g] = 1'b0;
        model_mode_vld = 1'b1; model_mode = uv[g]; model_ptr = (g + 1) % NREQ;
        first = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_wraparound();
    int lat; logic [NREQ-1:0] v; logic [7:0] s; logic c, e, u;
    u = model_mode;
    single_op(NREQ - 2, 8'h01, 8'h02, u, lat, v, s, c, e);
    model_mode_vld = 1'b1; model_ptr = NREQ - 1;
    drive_req(0, 8'h10, 8'h20, u);
    drive_req(NREQ - 1, 8'h30, 8'h40, u);
    wait_rsp(lat, v, s, c, e);
    n_checks++; if ({lat == 3, v} !== {1'b1, onehot(NREQ - 1)}) begin n_fail++; $display("FAIL wrap_first: got lat %0d valid %b expected lat 3 valid %b", lat, v, onehot(NREQ - 1)); end
    req[NREQ-1] = 1'b0;
    wait_rsp(lat, v, s, c, e);
    n_checks++; if ({lat == 4, v} !== {1'b1, onehot(0)}) begin n_fail++; $display("FAIL wrap_second: got lat %0d valid %b expected lat 4 valid %b", lat, v, onehot(0)); end
    n_checks++; if ({c, s} !== exp_result(8'h10, 8'h20, u)) begin n_fail++; $display("FAIL wrap_result: got %0h expected %0h", {c, s}, exp_result(8'h10, 8'h20, u)); end
    req[0] = 1'b0;
    step();
    model_ptr = 1;
  endtask

  task automatic test_timeout();
    int lat, idx, el, cfg0; logic [NREQ-1:0] v; logic [7:0] s, a, b; logic c, e, u; logic [8:0] er;
    u = model_mode; el = exp_lat(u);
    idx = $urandom_range(0, NREQ - 1);
    ready_en = 1'b0;
    single_op(idx, 8'($urandom), 8'($urandom), u, lat, v, s, c, e);
    ready_en = 1'b1;
    n_checks++; if ({v, e, c, s} !== {onehot(idx), 1'b1, 9'd0}) begin n_fail++; $display("FAIL timeout_rsp: got %0h expected %0h", {v, e, c, s}, {onehot(idx), 1'b1, 9'd0}); end
    n_checks++; if (lat < el + int'(TIMEOUT) - 1 || lat > el + int'(TIMEOUT)) begin n_fail++; $display("FAIL timeout_latency: got %0d expected %0d..%0d", lat, el + TIMEOUT - 1, el + TIMEOUT); end
    model_mode_vld = 1'b0; model_ptr = (idx + 1) % NREQ;
    cfg0 = cfg_wr_cnt;
    idx = $urandom_range(0, NREQ - 1); a = 8'($urandom); b = 8'($urandom);
    er = exp_result(a, b, u);
    single_op(idx, a, b, u, lat, v, s, c, e);
    n_checks++; if (cfg_wr_cnt - cfg0 !== 1) begin n_fail++; $display("FAIL timeout_recfg: got %0d expected 1", cfg_wr_cnt - cfg0); end
    n_checks++; if ({lat == 4, v, e, c, s} !== {1'b1, onehot(idx), 1'b0, er}) begin n_fail++; $display("FAIL timeout_next_op: got lat %0d rsp %0h expected %0h", lat, {v, e, c, s}, {onehot(idx), 1'b0, er}); end
    model_mode_vld = 1'b1; model_ptr = (idx + 1) % NREQ;
  endtask

  task automatic test_reset_mid();
    int lat, idx, cfg0; logic [NREQ-1:0] v; logic [7:0] s, a, b; logic c, e, u, seen; logic [8:0] er;
    ready_en = 1'b0; seen = 1'b0;
    drive_req($urandom_range(0, NREQ - 1), 8'hA5, 8'h5A, 1'($urandom));
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = add_data_val;
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rstmid_issue_seen: got %b expected 1", seen); end
    step();
    reset = 1'b1; req = '0;
    step();
    n_checks++; if (all_outs !== '0) begin n_fail++; $display("FAIL rstmid_outs: got %0h expected 0", all_outs); end
    reset = 1'b0; ready_en = 1'b1;
    model_mode_vld = 1'b0; model_ptr = 0;
    step(); step();
    n_checks++; if (all_outs !== '0) begin n_fail++; $display("FAIL rstmid_no_rsp: got %0h expected 0", all_outs); end
    cfg0 = cfg_wr_cnt;
    idx = $urandom_range(0, NREQ - 1); a = 8'($urandom); b = 8'($urandom); u = 1'($urandom);
    er = exp_result(a, b, u);
    single_op(idx, a, b, u, lat, v, s, c, e);
    n_checks++; if (cfg_wr_cnt - cfg0 !== 1) begin n_fail++; $display("FAIL rstmid_cfg: got %0d expected 1", cfg_wr_cnt - cfg0); end
    n_checks++; if ({lat == 4, v, e, c, s} !== {1'b1, onehot(idx), 1'b0, er}) begin n_fail++; $display("FAIL rstmid_op: got lat %0d rsp %0h expected %0h", lat, {v, e, c, s}, {onehot(idx), 1'b0, er}); end
    model_mode_vld = 1'b1; model_mode = u; model_ptr = (idx + 1) % NREQ;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_offset();
    test_simultaneous();
    test_random_ops(12);
    test_alternate(6);
    test_back_to_back();
    test_arbitration(6);
    test_wraparound();
    test_timeout();
    test_reset_mid();
    n_checks++; if (overlap_cnt !== 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d cycles expected 0", overlap_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_share_ctrl.md
# adder_share_ctrl

Sequencer and round-robin arbiter that shares one `expand_8bit_addr` adder among `NREQ` requesters. It configures the adder's control register (offset-add mode) and offset register through the adder's register port. It issues one operation at a time and returns the registered sum and carry to the granted requester. It sits between client logic and the adder, and is the only master of the adder's `Value_*`, `Data_val` and `Des_*` inputs.

## Interface
- `NREQ`, 4: number of requesters (2–8).
- `TIMEOUT`, 4: WAIT cycles allowed for `add_data_ready` before an error response.
- `clk` input 1: single clock; all logic on its rising edge.
- `reset` input 1: synchronous reset, active-high.
- `req` input NREQ: per-requester request level; held with operands until its `rsp_valid`.
- `req_a` input 8*NREQ: packed operand A; requester i uses bits [8i+7:8i].
- `req_b` input 8*NREQ: packed operand B, same packing as `req_a`.
- `req_use_off` input NREQ: 1 requests A+B+offset, 0 requests A+B.
- `cfg_off_valid` input 1: host request to load a new offset value.
- `cfg_off_value` input 8: offset value to load.
- `cfg_off_done` output 1: one-cycle pulse when the offset write has been issued.
- `rsp_valid` output NREQ: one-hot, one-cycle response pulse.
- `rsp_sum` output 8: result; valid while `rsp_valid` is nonzero.
- `rsp_carry` output 1: carry out; valid while `rsp_valid` is nonzero.
- `rsp_err` output 1: timeout flag; valid while `rsp_valid` is nonzero.
- `busy` output 1: high in every state except IDLE.
- `add_value_a`, `add_value_b` output 8: adder operands.
- `add_data_val` output 1: adder compute strobe.
- `add_des_reg_valid` output 1: adder register-port transaction strobe.
- `add_des_wr_rd` output 1: adder register-port direction; 1 = write.
- `add_des_address` output 3: adder register address.
- `add_des_value` output 8: adder register write data.
- `add_sum_result` input 8: adder registered sum.
- `add_sum_carry` input 1: adder registered carry.
- `add_data_ready` input 1: adder result-valid flag.

## Operation
- FSM states: IDLE, OFFWR, CFG, ISSUE, WAIT, RESP. All outputs are registered.
- **IDLE**
  - If `cfg_off_valid` is high, go to OFFWR. Offset loads have priority over new grants.
  - Else, if any `req` bit is high, grant the first set bit at or after `rr_ptr`, searching in increasing index with wrap. Latch the granted index, operands and `use_off`.
  - After a grant: if `mode_vld`=0 or `mode`≠`use_off`, go to CFG; else go to ISSUE.
- **OFFWR**
  - Drive `add_des_reg_valid`=1, `add_des_wr_rd`=1, `add_des_address`=3'b001, `add_des_value`=`cfg_off_value`.
  - Pulse `cfg_off_done`. Return to IDLE.
- **CFG**
  - Register write: address 3'b000, value {7'b0, use_off}.
  - Set `mode`=`use_off`, `mode_vld`=1. Go to ISSUE.
- **ISSUE**
  - Drive `add_data_val`=1 with the latched operands; `add_des_reg_valid`=0.
  - `add_des_reg_valid` and `add_data_val` are never high in the same cycle.
  - Go to WAIT.
- **WAIT**
  - Hold `add_data_val`=0 and the operands.
  - If `add_data_ready`=1, capture `add_sum_result` and `add_sum_carry` and go to RESP.
  - Else increment the wait counter. At count `TIMEOUT`: capture sum=0, carry=0, set err=1, clear `mode_vld`, go to RESP.
- **RESP**
  - Set `rsp_valid`[granted]=1 with `rsp_sum`, `rsp_carry`, `rsp_err`.
  - Set `rr_ptr` = granted+1 mod NREQ. Go to IDLE.
- Requester rules:
  - The requester must drop `req` on the cycle after its `rsp_valid`. A `req` still high in IDLE is a new request.
  - `req` changes outside IDLE are ignored.
- Arithmetic: sums are modulo 256. The carry is the adder's final carry, unmodified.

## Timing
- Reset (synchronous, priority over all else):
  - State goes to IDLE; `rr_ptr`=0; `mode_vld`=0; wait counter=0.
  - All outputs go to 0: `rsp_*`, `cfg_off_done`, `busy`, `add_*`.
- Reset mid-operation aborts the operation with no response; the next grant always passes through CFG.
- Latency, grant cycle G in IDLE, mode match: ISSUE at G+1, WAIT at G+2 (the adder asserts ready on this cycle), `rsp_valid` at G+3.
- Latency with a mode change: `rsp_valid` at G+4.
- Offset load: OFFWR on the cycle after IDLE samples `cfg_off_valid`; `cfg_off_done` in that same OFFWR cycle.
- Throughput: back-to-back same-mode operations take one response per 4 cycles (RESP → IDLE → ISSUE → WAIT → RESP).
- Simultaneous `cfg_off_valid` and `req` in IDLE: the offset write runs first, then the grant follows in the next IDLE cycle.
- Wrap-around: with `rr_ptr`=NREQ-1 and requesters 0 and NREQ-1 pending, NREQ-1 wins, then `rr_ptr` becomes 0.

## Test plan
- Reset, then req[2]=1, a=8'h12, b=8'h34, use_off=0 -> one CFG write (addr 0, data 8'h00), then rsp_valid=4'b0100, sum=8'h46, carry=0, err=0, four cycles after grant.
- Offset load 8'h05, then req[0] with a=8'hF0, b=8'h0F, use_off=1 -> OFFWR write (addr 1, 8'h05), CFG (addr 0, 8'h01), rsp sum=8'h04, carry=1.
- All four req high continuously, same mode -> grants in order 0,1,2,3,0; each response 4 cycles apart; no CFG after the first.
- Alternate use_off on successive requests -> a CFG write before every ISSUE; reg_valid and data_val never overlap.
- Tie add_data_ready low -> rsp_err=1 and sum=0 after TIMEOUT WAIT cycles; the next operation issues a CFG write.
- Assert reset during WAIT -> next cycle all outputs 0, no rsp_valid; a subsequent request starts from CFG and completes correctly.
